// File: rtl/tap_player.sv
// tap_player: walks a TAP image in synchronous memory and emits the ZX Spectrum ROM-loader mic waveform.
// Optional TAP_AUTOSTOP_EN: after each block's pause, hold until a rising edge of play.
module tap_player #(
    parameter int unsigned ADDR_W     = 15,
    parameter int unsigned CLK_DIV    = 1,
    parameter int unsigned PILOT_TS   = 2168,
    parameter int unsigned SYNC1_TS   = 667,
    parameter int unsigned SYNC2_TS   = 735,
    parameter int unsigned BIT0_TS    = 855,
    parameter int unsigned BIT1_TS    = 1710,
    parameter int unsigned PILOT_HDR  = 8063,
    parameter int unsigned PILOT_DATA = 3223,
    parameter int unsigned PAUSE_TS   = 3500000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              play,
    input  logic              rewind,
    input  logic [ADDR_W-1:0] tap_size,
    output logic [ADDR_W-1:0] tap_address,
    input  logic [7:0]        tap_data,
    output logic              mic,
    output logic              busy,
    output logic              block_done,
    output logic              eof
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned MAXT = max2(max2(max2(PAUSE_TS, PILOT_TS), max2(SYNC1_TS, SYNC2_TS)),
                                        max2(BIT0_TS, BIT1_TS)) * CLK_DIV;
    localparam int unsigned TW   = (MAXT > 1) ? $clog2(MAXT) : 1;
    localparam int unsigned PMAX = max2(PILOT_HDR, PILOT_DATA);
    localparam int unsigned PCW  = $clog2(PMAX + 1);

    localparam logic [TW-1:0] L_PILOT = TW'(PILOT_TS * CLK_DIV - 1);
    localparam logic [TW-1:0] L_SYNC1 = TW'(SYNC1_TS * CLK_DIV - 1);
    localparam logic [TW-1:0] L_SYNC2 = TW'(SYNC2_TS * CLK_DIV - 1);
    localparam logic [TW-1:0] L_BIT0  = TW'(BIT0_TS * CLK_DIV - 1);
    localparam logic [TW-1:0] L_BIT1  = TW'(BIT1_TS * CLK_DIV - 1);
    localparam logic [TW-1:0] L_PAUSE = TW'(PAUSE_TS * CLK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_LENL,
        S_RD_LENH,
        S_RD_FLAG,
        S_PILOT,
        S_SYNC1,
        S_SYNC2,
        S_DATA,
        S_PAUSE,
`ifdef TAP_AUTOSTOP_EN
        S_HOLD,
`endif
        S_EOF
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [ADDR_W-1:0]  r_pos, r_size;
    logic [7:0]         r_lenl, r_byte, r_next;
    logic [15:0]        r_len;
    logic [1:0]         r_fcnt;
    logic [TW-1:0]      r_timer;
    logic [PCW-1:0]     r_pilot;
    logic [2:0]         r_bitcnt;
    logic               r_half, r_have_next, r_trunc, r_mic, r_block_done;
    logic               w_clr, w_tick, w_fetched, w_past_end, w_pf_need, w_done, w_last_half;
    logic [TW-1:0]      w_ld_cur, w_ld_shift, w_ld_next;

`ifdef TAP_AUTOSTOP_EN
    logic r_play_d;
    always_ff @(posedge clock) begin
        if (reset) r_play_d <= 1'b0;
        else       r_play_d <= play;
    end
`endif

    assign w_clr       = reset || rewind;
    assign w_tick      = (r_timer == '0);
    assign w_fetched   = (r_fcnt == 2'd2);
    assign w_past_end  = (r_pos >= r_size);
    assign w_last_half = r_half && (r_bitcnt == 3'd7);
    // Next byte is fetched while the last bit of the current byte plays.
    assign w_pf_need   = (r_bitcnt == 3'd7) && (r_len != 16'd0) && !r_have_next && !r_trunc;
    assign w_ld_cur    = r_byte[7] ? L_BIT1 : L_BIT0;
    assign w_ld_shift  = r_byte[6] ? L_BIT1 : L_BIT0;
    assign w_ld_next   = r_next[7] ? L_BIT1 : L_BIT0;

    always_ff @(posedge clock) begin
        if (w_clr) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        if (play) begin
            case (r_state)
                S_IDLE:    w_state_nxt = S_RD_LENL;
                S_RD_LENL: if (w_past_end) w_state_nxt = S_EOF;
                           else if (w_fetched) w_state_nxt = S_RD_LENH;
                S_RD_LENH: if (w_past_end) w_state_nxt = S_EOF;
                           else if (w_fetched)
                               w_state_nxt = ({tap_data, r_lenl} == 16'd0) ? S_RD_LENL : S_RD_FLAG;
                S_RD_FLAG: if (w_past_end) w_state_nxt = S_EOF;
                           else if (w_fetched) w_state_nxt = S_PILOT;
                S_PILOT:   if (w_tick && r_pilot == PCW'(1)) w_state_nxt = S_SYNC1;
                S_SYNC1:   if (w_tick) w_state_nxt = S_SYNC2;
                S_SYNC2:   if (w_tick) w_state_nxt = S_DATA;
                S_DATA:    if (w_tick && w_last_half && !r_have_next)
                               w_state_nxt = r_trunc ? S_EOF : S_PAUSE;
                S_PAUSE: begin
                    if (w_tick) begin
                        w_done = 1'b1;
`ifdef TAP_AUTOSTOP_EN
                        w_state_nxt = w_past_end ? S_EOF : S_HOLD;
`else
                        w_state_nxt = w_past_end ? S_EOF : S_RD_LENL;
`endif
                    end
                end
`ifdef TAP_AUTOSTOP_EN
                S_HOLD:    if (!r_play_d) w_state_nxt = S_RD_LENL;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_clr) begin
            r_pos        <= '0;
            r_size       <= '0;
            r_lenl       <= '0;
            r_len        <= '0;
            r_fcnt       <= '0;
            r_timer      <= '0;
            r_pilot      <= '0;
            r_byte       <= '0;
            r_next       <= '0;
            r_bitcnt     <= '0;
            r_half       <= 1'b0;
            r_have_next  <= 1'b0;
            r_trunc      <= 1'b0;
            r_mic        <= 1'b0;
            r_block_done <= 1'b0;
        end else begin
            r_block_done <= w_done;
            if (play) begin
                case (r_state)
                    S_IDLE: begin
                        r_size <= tap_size;
                        r_fcnt <= '0;
                    end
                    S_RD_LENL, S_RD_LENH, S_RD_FLAG: begin
                        if (!w_past_end) begin
                            if (w_fetched) begin
                                r_fcnt <= '0;
                                r_pos  <= r_pos + ADDR_W'(1);
                                if (r_state == S_RD_LENL) begin
                                    r_lenl <= tap_data;
                                end else if (r_state == S_RD_LENH) begin
                                    r_len <= {tap_data, r_lenl};
                                end else begin
                                    r_len       <= r_len - 16'd1;
                                    r_byte      <= tap_data;
                                    r_pilot     <= tap_data[7] ? PCW'(PILOT_DATA) : PCW'(PILOT_HDR);
                                    r_timer     <= L_PILOT;
                                    r_bitcnt    <= '0;
                                    r_half      <= 1'b0;
                                    r_have_next <= 1'b0;
                                    r_trunc     <= 1'b0;
                                end
                            end else begin
                                r_fcnt <= r_fcnt + 2'd1;
                            end
                        end
                    end
                    S_PILOT: begin
                        if (w_tick) begin
                            r_mic <= ~r_mic;
                            if (r_pilot == PCW'(1)) begin
                                r_timer <= L_SYNC1;
                            end else begin
                                r_pilot <= r_pilot - PCW'(1);
                                r_timer <= L_PILOT;
                            end
                        end else begin
                            r_timer <= r_timer - TW'(1);
                        end
                    end
                    S_SYNC1: begin
                        if (w_tick) begin
                            r_mic   <= ~r_mic;
                            r_timer <= L_SYNC2;
                        end else begin
                            r_timer <= r_timer - TW'(1);
                        end
                    end
                    S_SYNC2: begin
                        if (w_tick) begin
                            r_mic   <= ~r_mic;
                            r_timer <= w_ld_cur;
                        end else begin
                            r_timer <= r_timer - TW'(1);
                        end
                    end
                    S_DATA: begin
                        if (w_pf_need) begin
                            if (w_past_end) begin
                                r_trunc <= 1'b1;
                            end else if (w_fetched) begin
                                r_next      <= tap_data;
                                r_pos       <= r_pos + ADDR_W'(1);
                                r_len       <= r_len - 16'd1;
                                r_have_next <= 1'b1;
                                r_fcnt      <= '0;
                            end else begin
                                r_fcnt <= r_fcnt + 2'd1;
                            end
                        end
                        if (w_tick) begin
                            r_mic <= ~r_mic;
                            if (!r_half) begin
                                r_half  <= 1'b1;
                                r_timer <= w_ld_cur;
                            end else begin
                                r_half <= 1'b0;
                                if (r_bitcnt != 3'd7) begin
                                    r_bitcnt <= r_bitcnt + 3'd1;
                                    r_byte   <= {r_byte[6:0], 1'b0};
                                    r_timer  <= w_ld_shift;
                                end else if (r_have_next) begin
                                    r_byte      <= r_next;
                                    r_bitcnt    <= '0;
                                    r_have_next <= 1'b0;
                                    r_timer     <= w_ld_next;
                                end else begin
                                    r_timer <= L_PAUSE;
                                end
                            end
                        end else begin
                            r_timer <= r_timer - TW'(1);
                        end
                    end
                    S_PAUSE: begin
                        if (!w_tick) r_timer <= r_timer - TW'(1);
                    end
                    default: ;
                endcase
                if (r_state == S_PAUSE || w_state_nxt == S_EOF) r_mic <= 1'b0;
            end
        end
    end

    assign tap_address = r_pos;
    assign mic         = r_mic;
    assign block_done  = r_block_done;
    assign eof         = (r_state == S_EOF);
`ifdef TAP_AUTOSTOP_EN
    assign busy        = !(r_state == S_IDLE || r_state == S_EOF || r_state == S_HOLD);
`else
    assign busy        = !(r_state == S_IDLE || r_state == S_EOF);
`endif

endmodule

// File: tb/tb_tap_player.sv
// Scoreboard bench for tap_player: expected mic half-pulse intervals and status events are queued,
// a negedge monitor pops and compares them as the DUT produces them. T-state lengths are scaled down.
module tb_tap_player;

    localparam int AW      = 15;
    localparam int T_PILOT = 217;
    localparam int T_SYNC1 = 67;
    localparam int T_SYNC2 = 74;
    localparam int T_BIT0  = 86;
    localparam int T_BIT1  = 171;
    localparam int N_HDR   = 4;
    localparam int N_DATA  = 2;
    localparam int T_PAUSE = 100;

    localparam int K_TOG  = 0;
    localparam int K_DONE = 1;
    localparam int K_EOF  = 2;

    typedef struct {
        int kind;
        int ival;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset, play, rewind;
    logic [AW-1:0] tap_size, tap_address;
    logic [7:0]    tap_data, m1;
    logic          mic, busy, block_done, eof;
    logic [7:0]    mem [0:15];

    ev_t  sb[$];
    int   nchecks = 0, nerr = 0;
    int   cyc = 0, last_tog = 0, tog_count = 0;
    bit   mon_en = 1'b0;
    logic mic_prev = 1'b0, eof_prev = 1'b0;

    always #5 clk = ~clk;

    tap_player #(
        .ADDR_W(AW), .CLK_DIV(1), .PILOT_TS(T_PILOT), .SYNC1_TS(T_SYNC1), .SYNC2_TS(T_SYNC2),
        .BIT0_TS(T_BIT0), .BIT1_TS(T_BIT1), .PILOT_HDR(N_HDR), .PILOT_DATA(N_DATA), .PAUSE_TS(T_PAUSE)
    ) dut (
        .clock(clk), .reset(reset), .play(play), .rewind(rewind), .tap_size(tap_size),
        .tap_address(tap_address), .tap_data(tap_data), .mic(mic), .busy(busy),
        .block_done(block_done), .eof(eof)
    );

    // Two-cycle synchronous memory.
    always @(posedge clk) begin
        m1       <= mem[tap_address[3:0]];
        tap_data <= m1;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        nchecks++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int k, input int iv);
        ev_t e;
        e.kind = k;
        e.ival = iv;
        sb.push_back(e);
    endtask

    task automatic push_lead(input int npilot, input int stretch);
        push(K_TOG, -1);
        for (int i = 1; i < npilot; i++) push(K_TOG, (i == 2) ? T_PILOT + stretch : T_PILOT);
        push(K_TOG, T_SYNC1);
        push(K_TOG, T_SYNC2);
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            push(K_TOG, b[i] ? T_BIT1 : T_BIT0);
            push(K_TOG, b[i] ? T_BIT1 : T_BIT0);
        end
    endtask

    task automatic push_img1(input int stretch);
        push_lead(N_HDR, stretch);
        push_byte(8'h00);
        push_byte(8'hA5);
        push(K_DONE, T_PAUSE);
        push(K_EOF, T_PAUSE);
    endtask

    task automatic see(input int kind, input string name);
        ev_t e;
        int  iv;
        iv = cyc - last_tog;
        if (sb.size() == 0) begin
            nchecks++;
            nerr++;
            $display("FAIL %s: got unexpected event kind %0d, expected no event", name, kind);
        end else begin
            e = sb.pop_front();
            chk({name, " kind"}, kind, e.kind);
            if (e.ival >= 0) chk({name, " interval"}, iv, e.ival);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en) begin
                if (mic !== mic_prev) begin
                    see(K_TOG, "mic_toggle");
                    last_tog = cyc;
                    tog_count++;
                end
                if (block_done) see(K_DONE, "block_done");
                if (eof && !eof_prev) see(K_EOF, "eof_rise");
            end
            mic_prev = mic;
            eof_prev = eof;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start(input logic [63:0] img, input int n, input int size);
        mon_en = 1'b0;
        play   = 1'b0;
        rewind = 1'b0;
        reset  = 1'b1;
        sb.delete();
        for (int i = 0; i < 16; i++) mem[i] = 8'hEE;
        for (int i = 0; i < n; i++) mem[i] = img[8*(n-1-i) +: 8];
        tap_size = AW'(size);
        step(4);
        chk("reset_state", {tap_address, mic, busy, block_done, eof}, 0);
        reset = 1'b0;
        step(1);
        tog_count = 0;
    endtask

    task automatic wait_eof(input string name);
        int n = 0;
        while (!eof && n < 20000) begin
            step(1);
            n++;
        end
        chk({name, " eof_reached"}, eof, 1);
        step(5);
        chk({name, " scoreboard_drained"}, sb.size(), 0);
    endtask

    task automatic wait_tog(input int k, input string name);
        int n = 0;
        while (tog_count < k && n < 5000) begin
            step(1);
            n++;
        end
        chk({name, " toggles_reached"}, (tog_count >= k) ? 1 : 0, 1);
    endtask

    initial begin
        logic [AW-1:0] a0;
        logic          m0;
        bit            ok;

        reset    = 1'b1;
        play     = 1'b0;
        rewind   = 1'b0;
        tap_size = '0;

        start(64'h020000A5, 4, 4);
        push_img1(0);
        mon_en = 1'b1;
        play   = 1'b1;
        wait_eof("img_hdr_block");

        start(64'h0100FF, 3, 3);
        push_lead(N_DATA, 0);
        push_byte(8'hFF);
        push(K_DONE, T_PAUSE);
        push(K_EOF, T_PAUSE);
        mon_en = 1'b1;
        play   = 1'b1;
        wait_eof("img_flag_only");

        start(64'h0000010080, 5, 5);
        push_lead(N_DATA, 0);
        push_byte(8'h80);
        push(K_DONE, T_PAUSE);
        push(K_EOF, T_PAUSE);
        mon_en = 1'b1;
        play   = 1'b1;
        wait_eof("img_zero_len_skip");

        start(64'h05000011, 4, 4);
        push_lead(N_HDR, 0);
        push_byte(8'h00);
        push_byte(8'h11);
        push(K_EOF, 0);
        mon_en = 1'b1;
        play   = 1'b1;
        wait_eof("img_truncated");

        start(64'h020000A5, 4, 4);
        push_img1(500);
        mon_en = 1'b1;
        play   = 1'b1;
        wait_tog(2, "freeze");
        step(50);
        a0   = tap_address;
        m0   = mic;
        ok   = 1'b1;
        play = 1'b0;
        repeat (500) begin
            step(1);
            if (mic !== m0 || tap_address !== a0) ok = 1'b0;
        end
        play = 1'b1;
        chk("freeze_stable", ok, 1);
        wait_eof("freeze");

        start(64'h020000A5, 4, 4);
        push_img1(0);
        mon_en = 1'b1;
        play   = 1'b1;
        wait_tog(10, "rewind");
        chk("pre_rewind_addr", tap_address, 3);
        mon_en = 1'b0;
        sb.delete();
        rewind = 1'b1;
        step(1);
        rewind = 1'b0;
        chk("rewind_state", {tap_address, mic, busy, eof}, 0);
        step(2);
        push_img1(0);
        mon_en = 1'b1;
        wait_eof("rewind_replay");

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
